// File: rtl/color_pkg.sv
// Shared colour codes, FSM states and RGB levels for the pattern generator and the colour detector.
package color_pkg;

  localparam logic [1:0] COL_BLACK = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  // Primary level must clear the detector threshold (>=150); off-channels stay at or below 100.
  localparam logic [7:0] DEF_HIGH = 8'd200;
  localparam logic [7:0] DEF_LOW  = 8'd50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t color_to_rgb(input logic [1:0] code,
                                        input logic [7:0] hi,
                                        input logic [7:0] lo);
    rgb_t c;
    c = '0;
    case (code)
      COL_RED:   begin c.r = hi; c.g = lo; c.b = lo; end
      COL_GREEN: begin c.r = lo; c.g = hi; c.b = lo; end
      COL_BLUE:  begin c.r = lo; c.g = lo; c.b = hi; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/color_pattern_gen.sv
// Turns (colour, length) commands into a registered RGB pixel stream; first pixel one cycle after accept.
// Stalls hold pixel and last flag stable; new commands are refused (cmd_ready=0) until back in IDLE.
module color_pattern_gen
  import color_pkg::*;
#(
  parameter logic [7:0] HIGH_LEVEL = DEF_HIGH,
  parameter logic [7:0] LOW_LEVEL  = DEF_LOW,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_color,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [7:0]       r_out,
  output logic [7:0]       g_out,
  output logic [7:0]       b_out,
  output logic             pix_last,
  output logic             done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  rgb_t             rgb_q, rgb_d;
  logic             pix_valid_q, pix_valid_d;
  logic             pix_last_q, pix_last_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    rgb_d       = rgb_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rem_d       = cmd_len;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
          if (cmd_len != '0) begin
            state_d     = STREAM;
            rgb_d       = color_to_rgb(cmd_color, HIGH_LEVEL, LOW_LEVEL);
            pix_valid_d = 1'b1;
            pix_last_d  = (cmd_len == ONE);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (pix_valid_q && pix_ready) begin
          rem_d      = rem_q - ONE;
          // Look one pixel ahead so pix_last stays a registered output.
          pix_last_d = (rem_q == TWO);
          if (pix_last_q) begin
            state_d     = DONE;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            rgb_d       = '0;
            done_d      = 1'b1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        rem_d       = '0;
        rgb_d       = '0;
        pix_valid_d = 1'b0;
        pix_last_d  = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;
  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
